// File: rtl/phase_seq.sv
// phase_seq: triggered multi-phase sequencer.
// A rising edge on trig (while idle) captures the per-phase hold lengths, waits
// START_DLY edges, then walks a one-hot token through phase[0..N_PH-1], holding
// each phase for its captured length. A full pass ends with a done pulse and
// either returns to idle or, with loop_en, wraps to phase 0 using freshly
// captured lengths. abort ends a sequence at once with no done pulse.
// Ports:
//   clk      clock, all state on posedge
//   rst      synchronous active-high reset
//   trig     level input; a rising edge starts a sequence from idle
//   hold_len packed hold lengths, field i = hold_len[i*CW +: CW]
//   loop_en  wrap from the last phase back to phase 0
//   abort    terminate a running sequence
//   phase    one-hot active phase, zero when not running
//   busy     high from trigger accept until the sequence ends
//   done     one-cycle pulse at the end of each full pass
//   err      one-cycle pulse when a start is rejected (a zero hold field)
module phase_seq #(
  parameter int unsigned N_PH      = 3,
  parameter int unsigned CW        = 4,
  parameter int unsigned START_DLY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trig,
  input  logic [N_PH*CW-1:0] hold_len,
  input  logic               loop_en,
  input  logic               abort,
  output logic [N_PH-1:0]    phase,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // The counter serves both the start delay and the hold lengths.
  localparam int unsigned CntW = (CW > 4) ? CW : 4;
  localparam int unsigned IdxW = $clog2(N_PH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_PH - 1);
  // Phase 0 is registered START_DLY-1 edges after the accept edge.
  localparam logic [CntW-1:0] WaitLoad = CntW'((START_DLY >= 2) ? START_DLY - 2 : 0);
  localparam logic [N_PH-1:0] PhFirst = N_PH'(1);

  typedef enum logic [1:0] {StIdle, StWait, StRun} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [N_PH*CW-1:0] shadow_q, shadow_d;
  logic [N_PH-1:0]    phase_q, phase_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               trig_q;
  logic               rise;

  function automatic logic any_zero(input logic [N_PH*CW-1:0] h);
    logic z;
    z = 1'b0;
    for (int i = 0; i < int'(N_PH); i++) begin
      if (h[i*CW +: CW] == '0) z = 1'b1;
    end
    return z;
  endfunction

  // Counter load for a phase: the phase is held for (field) edges.
  function automatic logic [CntW-1:0] hold_m1(input logic [N_PH*CW-1:0] h,
                                              input logic [IdxW-1:0]    i);
    return CntW'(h[int'(i)*CW +: CW]) - CntW'(1);
  endfunction

  assign rise = trig & ~trig_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    phase_d  = phase_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise && !abort) begin
          shadow_d = hold_len;
          if (any_zero(hold_len)) begin
            err_d = 1'b1;
          end else if (START_DLY <= 1) begin
            state_d = StRun;
            busy_d  = 1'b1;
            idx_d   = '0;
            phase_d = PhFirst;
            cnt_d   = hold_m1(hold_len, '0);
          end else begin
            state_d = StWait;
            busy_d  = 1'b1;
            cnt_d   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          phase_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StRun;
          idx_d   = '0;
          phase_d = PhFirst;
          cnt_d   = hold_m1(shadow_q, '0);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          phase_d = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (idx_q == LastIdx) begin
          done_d = 1'b1;
          if (loop_en && !any_zero(hold_len)) begin
            shadow_d = hold_len;
            idx_d    = '0;
            phase_d  = PhFirst;
            cnt_d    = hold_m1(hold_len, '0);
          end else begin
            // A wrap that recaptures a zero field is rejected like a bad start.
            err_d   = loop_en;
            if (loop_en) shadow_d = hold_len;
            state_d = StIdle;
            busy_d  = 1'b0;
            phase_d = '0;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end else begin
          idx_d   = idx_q + IdxW'(1);
          phase_d = phase_q << 1;
          cnt_d   = hold_m1(shadow_q, idx_q + IdxW'(1));
        end
      end
      default: begin
        state_d = StIdle;
        phase_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      phase_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      trig_q   <= 1'b1;  // trig held high through reset is not a rise
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      phase_q  <= phase_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      trig_q   <= trig;
    end
  end

  assign phase = phase_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: doc/phase_seq.md
PHASE_SEQ -- requirements
Module: phase_seq

Interface
REQ-001 Parameter N_PH, default 3: number of phases (channels), legal range 2..8.
REQ-002 Parameter CW, default 4: width of each per-phase hold-length field.
REQ-003 Parameter START_DLY, default 3: edges from trigger rise to first phase-0 sample, legal range 1..15.
REQ-004 clk  input  1  single clock; all sampling on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 trig  input  1  level input; the block starts on its rising edge.
REQ-007 hold_len  input  N_PH*CW  packed per-phase hold lengths; field i = hold_len[i*CW +: CW].
REQ-008 loop_en  input  1  high = wrap from the last phase back to phase 0.
REQ-009 abort  input  1  high = terminate the sequence immediately.
REQ-010 phase  output  N_PH  one-hot active phase; all zeros when not running.
REQ-011 busy  output  1  high from trigger accept until the sequence ends.
REQ-012 done  output  1  single-cycle pulse at the end of each full pass.
REQ-013 err  output  1  single-cycle pulse on rejected start.

Function
REQ-014 Rise detection: a rise occurs at edge k when trig is sampled 1 at k and 0 at k-1; the internal trig history register loads 1 on reset.
REQ-015 FSM states: IDLE, WAIT, RUN; state and a phase-index register are the only control state.
REQ-016 IDLE + rise + no abort: the block captures hold_len into a shadow register at edge k; a rise seen in WAIT or RUN is ignored.
REQ-017 If any captured field equals 0: err is sampled 1 at edge k+1 only, state stays IDLE, and phase and busy stay 0.
REQ-018 If all fields are nonzero: state goes to WAIT, busy is sampled 1 from edge k+1, and phase[0] is first sampled 1 at edge k+START_DLY.
REQ-019 phase[i] is sampled 1 for exactly shadow field i consecutive edges (1..2^CW-1).
REQ-020 Handoff: phase[i] is sampled 0 at the same edge phase[i+1] is first sampled 1; there are no gap or overlap cycles.
REQ-021 End of pass, loop_en=0: at the edge phase[N_PH-1] is first sampled 0, done=1, busy=0, phase=0, and state goes to IDLE.
REQ-022 End of pass, loop_en=1 (sampled at the last hold cycle): done=1 and phase[0]=1 at the same edge, busy stays 1, and hold_len is recaptured at that wrap edge.
REQ-023 hold_len changes while running do not take effect until the next capture.
REQ-024 abort sampled 1 at edge m in WAIT or RUN: at edge m+1 phase=0 and busy=0, done is not pulsed, and state goes to IDLE.
REQ-025 Precedence: abort outranks trigger, phase advance and loop wrap; abort in IDLE has no effect.
REQ-026 phase is never multi-hot; the hold counter saturates at no value, and values are loaded fresh per phase.
REQ-027 All outputs are registered.

Reset
REQ-028 On rst sampled 1, the block goes to IDLE with phase=0, busy=0, done=0, err=0, trig history=1, and counters and shadow cleared.
REQ-029 Reset during WAIT or RUN ends the sequence at the next edge with no done pulse.
REQ-030 If trig is held high through reset release, it does not start a sequence; a new rise is required.

Verification (N_PH=3, CW=4, START_DLY=3, hold_len={4,4,4} unless stated)
REQ-031 Basic pass: trig rises, sampled at edge 10 -> phase=001 at edges 13-16, 010 at 17-20, 100 at 21-24; at edge 25 phase=000, done=1, busy=0.
REQ-032 Loop: loop_en=1, trig at edge 10 -> at edge 25 phase=001 and done=1; busy continuous; the second done comes at edge 37.
REQ-033 Abort: abort=1 at edge 18 -> at edge 19 phase=000 and busy=0; done stays 0 through edge 30.
REQ-034 Zero hold: hold_len field 1=0, trig at edge 10 -> err=1 at edge 11 only; phase=000 and busy=0 throughout.
REQ-035 Retrigger/unequal holds: hold_len={1,2,3} (phase0..2), trig at 10, re-rise at 14 -> phase0 at edge 13, phase1 at 14-15, phase2 at 16-18, done at 19; the re-rise is ignored.
REQ-036 Reset mid-run: rst=1 at edge 20 -> at edge 21 all outputs 0; trig held high gives no restart until it falls and rises again.
